parity_rx_check: RTL and testbench
==================================

PARITY_RX_CHECK -- requirements
Module: parity_rx_check

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame.
REQ-002 Parameter ODD_MODE, default 0: 0 means even parity (total ones over data+parity even); 1 means odd parity.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bit_en  input  1  bit-time strobe; rxd is sampled only in cycles where bit_en=1.
REQ-006 rxd  input  1  serial line, idle high.
REQ-007 data_out  output  DATA_W  last received data word, LSB first on the line.
REQ-008 data_valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 parity_err  output  1  parity mismatch for the frame flagged by data_valid.
REQ-010 frame_err  output  1  stop bit sampled low for the frame flagged by data_valid.
REQ-011 busy  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-012 Frame format: start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1); one bit per bit_en strobe.
REQ-013 States: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 IDLE: on bit_en with rxd=0 -> DATA; bit counter=0; parity accumulator cleared to ODD_MODE.
REQ-015 IDLE: rxd=0 without bit_en is ignored.
REQ-016 DATA: each bit_en shifts rxd into data bit[count] and XORs it into the accumulator; after bit DATA_W-1 -> PARITY.
REQ-017 PARITY: on bit_en, XOR rxd into the accumulator -> STOP; parity error exists iff accumulator is nonzero.
REQ-018 STOP: on bit_en, data_out, parity_err and frame_err update together and data_valid pulses high for exactly that one cycle.
REQ-019 STOP with rxd=1 -> IDLE; STOP with rxd=0 -> frame_err=1, then -> WAIT_HIGH.
REQ-020 WAIT_HIGH: on bit_en with rxd=1 -> IDLE; the line must be seen high before a new start is accepted.
REQ-021 Back-to-back frames: a start bit on the first bit_en after a good stop is accepted.
REQ-022 data_out, parity_err and frame_err hold their values until the next data_valid.
REQ-023 Cycles without bit_en change no state, counter or accumulator.
REQ-024 Counter width is clog2(DATA_W).
REQ-025 Counter wraps to 0 on leaving DATA.

Reset
REQ-026 While rst is high: state=IDLE, counter=0, accumulator=0.
REQ-027 While rst is high: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-frame abandons the frame with no data_valid.
REQ-029 After reset deasserts, the first accepted event is a fresh start bit.

Structure
REQ-030 Shared package parity_pkg holds the state enumeration and the default DATA_W constant.
REQ-031 Package parity_pkg is reusable by the matching transmitter.
REQ-032 One sub-module, parity_acc: a 1-bit XOR-toggle flop with clear/load-init.
REQ-033 parity_acc is instantiated once; everything else is flat.

Verification
REQ-034 Even mode, frame 0xA5 with parity 0, stop 1 -> data_valid one cycle, data_out=0xA5, parity_err=0, frame_err=0.
REQ-035 Even mode, frame 0x01 with parity 0 -> data_out=0x01, parity_err=1.
REQ-036 Odd mode, frame 0xFF with parity 1 -> parity_err=0.
REQ-037 Odd mode, frame 0xFF with parity 0 -> parity_err=1.
REQ-038 Stop bit 0 on 0x3C -> frame_err=1; a start bit before any high sample is ignored; after rxd=1, the next frame 0x5A is received correctly.
REQ-039 rst pulsed after 4 data bits -> no data_valid, busy=0; the following full frame 0x81 is received correctly.
REQ-040 Two frames back-to-back (0x12 then 0x34), bit_en every 3rd cycle -> two data_valid pulses, both with correct data and no errors.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: frame-level types and defaults shared by the parity receiver and transmitter.
`default_nettype none

package parity_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/parity_acc.sv
// parity_acc: single-bit XOR accumulator; clear loads init, toggle folds din into the running parity.
`default_nettype none

module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic init,
  input  logic toggle,
  input  logic din,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clear) begin
      q <= init;
    end else if (toggle) begin
      q <= q ^ din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_rx_check.sv
// parity_rx_check: strobe-driven serial receiver (start, data LSB first, parity, stop) with
// parity and framing error flags reported alongside each received word.
`default_nettype none

module parity_rx_check
  import parity_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ODD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rxd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic             ACC_INIT = (ODD_MODE != 0);

  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_sh;
  logic              acc_q;
  logic              acc_clear, acc_toggle;
  logic              shift_en, cnt_clr, cnt_inc, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_clear  = 1'b0;
    acc_toggle = 1'b0;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bit_en && !rxd) begin
          state_next = S_DATA;
          acc_clear  = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_en) begin
          shift_en   = 1'b1;
          acc_toggle = 1'b1;
          if (cnt == LAST_CNT) begin
            state_next = S_PARITY;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_en) begin
          acc_toggle = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_en) begin
          done       = 1'b1;
          state_next = rxd ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A low line after a bad stop cannot be trusted as a start bit.
        if (bit_en && rxd) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      data_sh <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (shift_en) begin
        data_sh[cnt] <= rxd;
      end
    end
  end

  parity_acc u_parity_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .init   (ACC_INIT),
    .toggle (acc_toggle),
    .din    (rxd),
    .q      (acc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= done;
      if (done) begin
        data_out   <= data_sh;
        parity_err <= acc_q;
        frame_err  <= ~rxd;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_parity_rx_check.sv
// tb_parity_rx_check: directed frames against an even-parity and an odd-parity receiver.
`default_nettype none

module tb_parity_rx_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       rxd = 1'b1;

  logic [7:0] e_data, o_data;
  logic       e_dv, e_pe, e_fe, e_busy;
  logic       o_dv, o_pe, o_fe, o_busy;

  int checks = 0;
  int errors = 0;

  // {parity_err, frame_err, data} captured at each data_valid
  logic [9:0] e_q[$];
  logic [9:0] o_q[$];

  always #5 clk = ~clk;

  parity_rx_check #(.DATA_W(8), .ODD_MODE(0)) dut_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rxd(rxd),
    .data_out(e_data), .data_valid(e_dv), .parity_err(e_pe),
    .frame_err(e_fe), .busy(e_busy)
  );

  parity_rx_check #(.DATA_W(8), .ODD_MODE(1)) dut_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rxd(rxd),
    .data_out(o_data), .data_valid(o_dv), .parity_err(o_pe),
    .frame_err(o_fe), .busy(o_busy)
  );

  always @(negedge clk) begin
    if (e_dv) e_q.push_back({e_pe, e_fe, e_data});
    if (o_dv) o_q.push_back({o_pe, o_fe, o_data});
  end

  // One bit per strobe; the line is flipped during idle gap cycles to show it is not sampled there.
  task automatic send_bit(input logic b, input int gap);
    rxd    = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
    for (int i = 1; i < gap; i++) begin
      rxd = ~b;
      @(posedge clk); #1;
    end
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    send_bit(stp, gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++;
    if ({e_data, e_dv, e_pe, e_fe, e_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_even: got data=%h dv=%b pe=%b fe=%b busy=%b, want all 0", e_data, e_dv, e_pe, e_fe, e_busy);
    end
    checks++;
    if ({o_data, o_dv, o_pe, o_fe, o_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_odd: got data=%h dv=%b pe=%b fe=%b busy=%b, want all 0", o_data, o_dv, o_pe, o_fe, o_busy);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_even_good;
    e_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    idle(3);
    checks++;
    if (e_q.size() != 1) begin
      errors++;
      $display("FAIL even_a5_pulses: got %0d data_valid pulses, want 1", e_q.size());
    end else begin
      checks++;
      if (e_q[0] !== {1'b0, 1'b0, 8'hA5}) begin
        errors++;
        $display("FAIL even_a5: got {pe,fe,data}=%h, want %h", e_q[0], {2'b00, 8'hA5});
      end
    end
    checks++;
    if (e_data !== 8'hA5 || e_dv !== 1'b0 || e_busy !== 1'b0) begin
      errors++;
      $display("FAIL even_a5_hold: got data=%h dv=%b busy=%b, want a5 0 0", e_data, e_dv, e_busy);
    end
  endtask

  task automatic test_even_parity_err;
    e_q.delete();
    send_frame(8'h01, 1'b0, 1'b1, 2);
    idle(2);
    checks++;
    if (e_q.size() != 1 || e_q[0] !== {1'b1, 1'b0, 8'h01}) begin
      errors++;
      $display("FAIL even_01_perr: got n=%0d last=%h, want n=1 %h", e_q.size(),
               (e_q.size() > 0) ? e_q[$] : 10'h0, {2'b10, 8'h01});
    end
  endtask

  task automatic test_odd_mode;
    o_q.delete();
    e_q.delete();
    send_frame(8'hFF, 1'b1, 1'b1, 1);
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    idle(2);
    checks++;
    if (o_q.size() != 2) begin
      errors++;
      $display("FAIL odd_ff_pulses: got %0d, want 2", o_q.size());
    end else begin
      checks++;
      if (o_q[0] !== {1'b0, 1'b0, 8'hFF}) begin
        errors++;
        $display("FAIL odd_ff_p1: got %h, want %h", o_q[0], {2'b00, 8'hFF});
      end
      checks++;
      if (o_q[1] !== {1'b1, 1'b0, 8'hFF}) begin
        errors++;
        $display("FAIL odd_ff_p0: got %h, want %h", o_q[1], {2'b10, 8'hFF});
      end
    end
    checks++;
    if (e_q.size() != 2 || e_q[0][9] !== 1'b1 || e_q[1][9] !== 1'b0) begin
      errors++;
      $display("FAIL even_ff_perr: got n=%0d, want n=2 with pe 1 then 0", e_q.size());
    end
  endtask

  task automatic test_frame_err;
    e_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    idle(1);
    checks++;
    if (e_q.size() != 1 || e_q[0] !== {1'b0, 1'b1, 8'h3C} || e_busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_3c: got n=%0d last=%h busy=%b, want n=1 %h busy=1", e_q.size(),
               (e_q.size() > 0) ? e_q[$] : 10'h0, e_busy, {2'b01, 8'h3C});
    end
    send_bit(1'b0, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    checks++;
    if (e_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_high: got busy=%b after low,low,high, want 0", e_busy);
    end
    e_q.delete();
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    idle(2);
    checks++;
    if (e_q.size() != 1 || e_q[0] !== {1'b0, 1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL recover_5a: got n=%0d last=%h, want n=1 %h", e_q.size(),
               (e_q.size() > 0) ? e_q[$] : 10'h0, {2'b00, 8'h5A});
    end
  endtask

  task automatic test_reset_mid_frame;
    e_q.delete();
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    checks++;
    if (e_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got busy=%b, want 1", e_busy);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (e_busy !== 1'b0 || e_data !== 8'h00 || e_fe !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b data=%h fe=%b, want 0 00 0", e_busy, e_data, e_fe);
    end
    idle(2);
    rst = 1'b0;
    idle(2);
    checks++;
    if (e_q.size() != 0 || e_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abandon: got %0d pulses busy=%b, want 0 0", e_q.size(), e_busy);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1);
    idle(2);
    checks++;
    if (e_q.size() != 1 || e_q[0] !== {1'b0, 1'b0, 8'h81}) begin
      errors++;
      $display("FAIL after_reset_81: got n=%0d last=%h, want n=1 %h", e_q.size(),
               (e_q.size() > 0) ? e_q[$] : 10'h0, {2'b00, 8'h81});
    end
  endtask

  task automatic test_back_to_back;
    e_q.delete();
    send_frame(8'h12, 1'b0, 1'b1, 3);
    send_frame(8'h34, 1'b1, 1'b1, 3);
    idle(3);
    checks++;
    if (e_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, want 2", e_q.size());
    end else begin
      checks++;
      if (e_q[0] !== {1'b0, 1'b0, 8'h12}) begin
        errors++;
        $display("FAIL b2b_12: got %h, want %h", e_q[0], {2'b00, 8'h12});
      end
      checks++;
      if (e_q[1] !== {1'b0, 1'b0, 8'h34}) begin
        errors++;
        $display("FAIL b2b_34: got %h, want %h", e_q[1], {2'b00, 8'h34});
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_good();
    test_even_parity_err();
    test_odd_mode();
    test_frame_err();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
